// File: rtl/telemetry_tx_pkg.sv
// -----------------------------------------------------------------------------
// telemetry_tx_pkg
// Shared frame constants, FSM state type, snapshot record and the helper
// functions that build each outbound telemetry byte (including the XOR
// checksum) from a captured snapshot.
// -----------------------------------------------------------------------------
package telemetry_tx_pkg;

    localparam logic [7:0] HDR_BYTE_DEF  = 8'hA5;
    localparam int         FRAME_BYTES   = 9;
    localparam int         BITS_PER_BYTE = 10;

    localparam logic [3:0] LAST_BYTE_IDX = 4'(FRAME_BYTES - 1);
    localparam logic [3:0] LAST_BIT_IDX  = 4'(BITS_PER_BYTE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Core signals frozen at frame start; flags = {pwr_up, moving, ovr_spd, batt_low}
    typedef struct packed {
        logic [11:0] batt;
        logic [10:0] lft_spd;
        logic [10:0] rght_spd;
        logic [3:0]  flags;
    } snap_t;

    // Payload bytes 1..7; any other index yields zero
    function automatic logic [7:0] payload_byte(input snap_t s, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = {4'b0000, s.flags};
            4'd2:    b = {4'b0000, s.batt[11:8]};
            4'd3:    b = s.batt[7:0];
            4'd4:    b = {5'b00000, s.lft_spd[10:8]};
            4'd5:    b = s.lft_spd[7:0];
            4'd6:    b = {5'b00000, s.rght_spd[10:8]};
            4'd7:    b = s.rght_spd[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // XOR of payload bytes 1..7; the header is deliberately excluded
    function automatic logic [7:0] checksum(input snap_t s);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 1; i < 8; i++) begin
            c = c ^ payload_byte(s, 4'(i));
        end
        return c;
    endfunction

    // Full frame byte selector: header, payload, then checksum last
    function automatic logic [7:0] frame_byte(input snap_t s, input logic [3:0] idx,
                                              input logic [7:0] hdr);
        logic [7:0] b;
        if (idx == 4'd0) begin
            b = hdr;
        end else if (idx == LAST_BYTE_IDX) begin
            b = checksum(s);
        end else begin
            b = payload_byte(s, idx);
        end
        return b;
    endfunction

endpackage

// File: rtl/telemetry_tx_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serializes one byte as 8N1 (start 0, data LSB first, stop 1), each bit held
// BAUD_DIV cycles. A load in the last cycle of a stop bit starts the next
// start bit on the very next cycle, so bytes can run back-to-back.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   load      : start a byte (takes priority over an in-flight byte)
//   byte_in   : byte to send, sampled with load
//   tx        : registered serial line, idle high
//   byte_done : high during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte
    import telemetry_tx_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int             CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  BAUD_MAX = CW'(BAUD_DIV - 1);

    logic [CW-1:0] baud_cnt_r;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic          active_r;
    logic          tx_r;

    // Baud/bit counting, shifting and the registered TX level
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r   <= 1'b0;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 10'h3FF;
            tx_r       <= 1'b1;
        end else if (load) begin
            // shift_r[0] is the start bit already being driven
            active_r   <= 1'b1;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {1'b1, byte_in, 1'b0};
            tx_r       <= 1'b0;
        end else if (active_r) begin
            if (baud_cnt_r == BAUD_MAX) begin
                baud_cnt_r <= '0;
                if (bit_cnt_r == LAST_BIT_IDX) begin
                    active_r  <= 1'b0;
                    bit_cnt_r <= 4'd0;
                    tx_r      <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    shift_r   <= {1'b1, shift_r[9:1]};
                    tx_r      <= shift_r[1];
                end
            end else begin
                baud_cnt_r <= baud_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            tx_r       <= 1'b1;
        end
    end

    assign tx        = tx_r;
    // Combinational so the owner can reload in the same edge with no gap
    assign byte_done = active_r && (baud_cnt_r == BAUD_MAX) && (bit_cnt_r == LAST_BIT_IDX);

endmodule

// File: rtl/telemetry_tx.sv
// -----------------------------------------------------------------------------
// telemetry_tx
// Sends a 9-byte status frame (header, flags, battery, wheel speeds, XOR
// checksum) as back-to-back 8N1 bytes. Inputs are snapshotted when send is
// accepted in IDLE; requests while busy are dropped.
//   clk, rst                         : clock, synchronous active-high reset
//   send                             : one-cycle frame request
//   batt, lft_spd, rght_spd          : data captured at frame start
//   pwr_up, moving, ovr_spd, batt_low: status flags captured at frame start
//   TX                               : serial out, idle high
//   busy                             : frame in progress
//   done                             : one-cycle pulse after the last stop bit
// -----------------------------------------------------------------------------
module telemetry_tx
    import telemetry_tx_pkg::*;
#(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [11:0] batt,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic        pwr_up,
    input  logic        moving,
    input  logic        ovr_spd,
    input  logic        batt_low,
    output logic        TX,
    output logic        busy,
    output logic        done
);

    state_t     state_r;
    snap_t      snap_r;
    logic [3:0] idx_r;
    logic       busy_r;
    logic       done_r;

    logic       load_s;
    logic [7:0] byte_in_s;
    logic       byte_done_s;

    // Byte 0 is always the header, so it can be loaded straight from IDLE
    // in the same edge the snapshot is taken.
    always_comb begin
        load_s    = 1'b0;
        byte_in_s = HDR_BYTE;
        if (state_r == IDLE) begin
            load_s    = send;
            byte_in_s = HDR_BYTE;
        end else begin
            load_s    = byte_done_s && (idx_r != LAST_BYTE_IDX);
            byte_in_s = frame_byte(snap_r, idx_r + 4'd1, HDR_BYTE);
        end
    end

    // Frame sequencing: snapshot, byte index, busy and done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            snap_r  <= '0;
            idx_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (send) begin
                        snap_r  <= '{batt: batt, lft_spd: lft_spd, rght_spd: rght_spd,
                                     flags: {pwr_up, moving, ovr_spd, batt_low}};
                        idx_r   <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= SEND;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SEND: begin
                    if (byte_done_s) begin
                        if (idx_r == LAST_BYTE_IDX) begin
                            state_r <= IDLE;
                            idx_r   <= 4'd0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 4'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .byte_in   (byte_in_s),
        .tx        (TX),
        .byte_done (byte_done_s)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_telemetry_tx.sv
// -----------------------------------------------------------------------------
// tb_telemetry_tx
// Randomized and directed stimulus for telemetry_tx with BAUD_DIV=4. A
// behavioural frame model predicts TX/busy/done every cycle; directed frames
// are also decoded from TX and compared against hand-computed bytes.
// -----------------------------------------------------------------------------
module tb_telemetry_tx;

    localparam int BD        = 4;
    localparam int FRAME_CYC = 90 * BD;
    localparam logic [71:0] NOMINAL_FRAME = 72'h60FF072301BC0A0CA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send = 1'b0;
    logic [11:0] batt = 12'h000;
    logic [10:0] lft_spd = 11'h000;
    logic [10:0] rght_spd = 11'h000;
    logic        pwr_up = 1'b0;
    logic        moving = 1'b0;
    logic        ovr_spd = 1'b0;
    logic        batt_low = 1'b0;
    logic        TX;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    telemetry_tx #(
        .BAUD_DIV (BD),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .send     (send),
        .batt     (batt),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .pwr_up   (pwr_up),
        .moving   (moving),
        .ovr_spd  (ovr_spd),
        .batt_low (batt_low),
        .TX       (TX),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bytes from the rules; byte k lives at bits [k*8 +: 8]
    function automatic logic [71:0] model_frame(input logic [11:0] b, input logic [10:0] l,
                                                input logic [10:0] r, input logic [3:0] f);
        logic [7:0]  by [9];
        logic [71:0] o;
        by[0] = 8'hA5;
        by[1] = {4'h0, f};
        by[2] = {4'h0, b[11:8]};
        by[3] = b[7:0];
        by[4] = {5'h00, l[10:8]};
        by[5] = l[7:0];
        by[6] = {5'h00, r[10:8]};
        by[7] = r[7:0];
        by[8] = 8'h00;
        for (int i = 1; i < 8; i++) by[8] = by[8] ^ by[i];
        o = '0;
        for (int i = 0; i < 9; i++) o[i*8 +: 8] = by[i];
        return o;
    endfunction

    // Cycle model: pos counts cycles since an accepted send (361 = done cycle)
    initial begin
        int          pos;
        logic [89:0] bits;
        logic [71:0] fr;
        logic        exp_tx;
        pos  = 0;
        bits = '1;
        forever begin
            @(posedge clk);
            if (rst) begin
                pos = 0;
            end else if ((pos == 0 || pos == FRAME_CYC + 1) && send) begin
                fr = model_frame(batt, lft_spd, rght_spd, {pwr_up, moving, ovr_spd, batt_low});
                for (int b = 0; b < 9; b++) begin
                    bits[b*10] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[b*10 + 1 + i] = fr[b*8 + i];
                    bits[b*10 + 9] = 1'b1;
                end
                pos = 1;
            end else if (pos == FRAME_CYC + 1) begin
                pos = 0;
            end else if (pos != 0) begin
                pos++;
            end
            #1;
            exp_tx = (pos >= 1 && pos <= FRAME_CYC) ? bits[(pos - 1) / BD] : 1'b1;
            chk("tx_cycle", {71'd0, TX}, {71'd0, exp_tx});
            chk("busy_cycle", {71'd0, busy}, {71'd0, (pos >= 1 && pos <= FRAME_CYC)});
            chk("done_cycle", {71'd0, done}, {71'd0, (pos == FRAME_CYC + 1)});
            if (done === 1'b1) done_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge inside the done cycle
    task automatic run_frame(input logic [11:0] b, input logic [10:0] l, input logic [10:0] r,
                             input logic [3:0] f, input bit mid_change, input bit mid_send,
                             output logic [71:0] dec);
        int          busy_cyc;
        int          d0;
        logic [89:0] raw;
        batt = b; lft_spd = l; rght_spd = r;
        {pwr_up, moving, ovr_spd, batt_low} = f;
        send = 1'b1;
        d0 = done_cnt;
        busy_cyc = 0;
        raw = '1;
        @(negedge clk);
        send = 1'b0;
        chk("start_bit_after_send", {71'd0, TX}, 72'd0);
        for (int n = 0; n < FRAME_CYC; n++) begin
            if (n > 0) @(negedge clk);
            if (busy === 1'b1) busy_cyc++;
            if (n % BD == 1) raw[n / BD] = TX;
            if (mid_change && n == 100) batt = 12'h000;
            send = (mid_send && n == 50) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        chk("busy_cycles", 72'(busy_cyc), 72'(FRAME_CYC));
        chk("done_at_end", {71'd0, done}, 72'd1);
        chk("busy_at_end", {71'd0, busy}, 72'd0);
        chk("done_pulses", 72'(done_cnt - d0), 72'd1);
        dec = '0;
        for (int k = 0; k < 9; k++) dec[k*8 +: 8] = raw[k*10 + 1 +: 8];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [71:0] dec;
        logic [11:0] rb;
        logic [10:0] rl, rr;
        logic [3:0]  rf;
        int          viol;
        int          d0;
        int          busy_seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0) viol++;
        end
        chk("idle_hold_violations", 72'(viol), 72'd0);

        // pin the model with the hand-computed nominal frame
        chk("model_nominal", model_frame(12'hABC, 11'h123, 11'h7FF, 4'b1100), NOMINAL_FRAME);
        chk("model_zero", model_frame(12'h000, 11'h000, 11'h000, 4'b0000), 72'h00000000000000_00A5);

        // nominal frame
        run_frame(12'hABC, 11'h123, 11'h7FF, 4'b1100, 1'b0, 1'b0, dec);
        chk("nominal_decode", dec, NOMINAL_FRAME);
        repeat (5) @(negedge clk);

        // snapshot: batt changes mid-frame
        run_frame(12'hABC, 11'h123, 11'h7FF, 4'b1100, 1'b1, 1'b0, dec);
        chk("snapshot_decode", dec, NOMINAL_FRAME);
        repeat (5) @(negedge clk);

        // send while busy is ignored
        run_frame(12'hABC, 11'h123, 11'h7FF, 4'b1100, 1'b0, 1'b1, dec);
        chk("busy_send_decode", dec, NOMINAL_FRAME);
        d0 = done_cnt;
        busy_seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        chk("no_second_frame", 72'(busy_seen), 72'd0);
        chk("no_extra_done", 72'(done_cnt - d0), 72'd0);

        // back-to-back: next send in the done cycle, then random chained frames
        run_frame(12'hABC, 11'h123, 11'h7FF, 4'b1100, 1'b0, 1'b0, dec);
        chk("b2b_first_decode", dec, NOMINAL_FRAME);
        for (int k = 0; k < 3; k++) begin
            rb = 12'($urandom); rl = 11'($urandom); rr = 11'($urandom); rf = 4'($urandom);
            run_frame(rb, rl, rr, rf, 1'b0, 1'b0, dec);
            chk("b2b_random_decode", dec, model_frame(rb, rl, rr, rf));
        end
        repeat (5) @(negedge clk);

        // reset during byte 4
        batt = 12'hABC; lft_spd = 11'h123; rght_spd = 11'h7FF;
        {pwr_up, moving, ovr_spd, batt_low} = 4'b1100;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (170) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", {71'd0, TX}, 72'd1);
        chk("rst_mid_busy", {71'd0, busy}, 72'd0);
        chk("rst_mid_done", {71'd0, done}, 72'd0);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        chk("rst_mid_no_done", 72'(done_cnt - d0), 72'd0);
        run_frame(12'hABC, 11'h123, 11'h7FF, 4'b1100, 1'b0, 1'b0, dec);
        chk("after_rst_decode", dec, NOMINAL_FRAME);

        // free-running random stimulus, checked cycle by cycle by the model
        d0 = done_cnt;
        repeat (3000) begin
            @(negedge clk);
            batt = 12'($urandom); lft_spd = 11'($urandom); rght_spd = 11'($urandom);
            {pwr_up, moving, ovr_spd, batt_low} = 4'($urandom);
            send = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
        end
        send = 1'b0;
        repeat (400) @(negedge clk);
        chk("random_frames_seen", {71'd0, (done_cnt - d0) > 0}, 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
